// File: rtl/rv_fetch_queue.sv
// RV32 fetch queue: prefetches aligned words and presents one 16/32-bit instruction per cycle, zero latency from queue head.
// Decode backpressure (i_ready low) lets the queue fill, and bus requests are only issued while a free word slot remains.
module rv_fetch_queue #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4,
    parameter int          LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_pc_target,
    input  logic             i_pc_select,
    input  logic             i_ready,
    input  logic [31:0]      i_data,
    input  logic             i_ack,
    output logic [31:0]      o_addr,
    output logic             o_cyc,
    output logic             o_valid,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_instruction,
    output logic             o_compressed,
    output logic [LVL_W-1:0] o_level
);
    localparam int               PW     = $clog2(DEPTH);
    localparam logic [31:0]      RST_PC = {RESET_ADDR[31:1], 1'b0};
    localparam logic [LVL_W-1:0] FULL   = LVL_W'(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [PW-1:0]    r_rp;
    logic [PW-1:0]    r_wp;
    logic [LVL_W-1:0] r_level;
    logic [31:0]      r_pc;
    logic [31:0]      r_addr;
    logic             r_cyc;
    logic             r_drop;

    logic [31:0]      w_head;
    logic [31:0]      w_next;
    logic [15:0]      w_hw;
    logic             w_hp;
    logic             w_is32;
    logic             w_valid;
    logic             w_take;
    logic             w_push;
    logic             w_pop;
    logic [LVL_W-1:0] w_level_nxt;

    // The half-word pointer is simply bit 1 of the presented PC.
    assign w_hp   = r_pc[1];
    assign w_head = r_mem[r_rp];
    assign w_next = r_mem[r_rp + PW'(1)];
    assign w_hw   = w_hp ? w_head[31:16] : w_head[15:0];
    assign w_is32 = (w_hw[1:0] == 2'b11);

    assign w_valid     = (w_is32 && w_hp) ? (r_level >= LVL_W'(2)) : (r_level != '0);
    assign w_take      = w_valid & i_ready & ~i_pc_select;
    assign w_pop       = w_take & (w_is32 | w_hp);
    assign w_push      = r_cyc & i_ack & ~r_drop & ~i_pc_select;
    assign w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

    always_comb begin
        o_instruction = 32'h0;
        o_compressed  = 1'b0;
        if (w_valid) begin
            if (!w_is32) begin
                o_instruction = {16'h0, w_hw};
                o_compressed  = 1'b1;
            end else if (w_hp) begin
                o_instruction = {w_next[15:0], w_head[31:16]};
            end else begin
                o_instruction = w_head;
            end
        end
    end

    assign o_valid = w_valid;
    assign o_pc    = r_pc;
    assign o_addr  = r_addr;
    assign o_cyc   = r_cyc;
    assign o_level = r_level;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rp    <= '0;
            r_wp    <= '0;
            r_level <= '0;
            r_pc    <= RST_PC;
            r_addr  <= {RST_PC[31:2], 2'b00};
            r_cyc   <= 1'b0;
            r_drop  <= 1'b0;
        end else if (i_pc_select) begin
            r_rp    <= '0;
            r_wp    <= '0;
            r_level <= '0;
            r_pc    <= {i_pc_target[31:1], 1'b0};
            // A stale request must still complete on the bus before the target can be fetched.
            if (r_cyc && !i_ack) begin
                r_drop <= 1'b1;
            end else begin
                r_drop <= 1'b0;
                r_cyc  <= 1'b1;
                r_addr <= {i_pc_target[31:2], 2'b00};
            end
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            r_level <= w_level_nxt;
            if (w_take) r_pc <= r_pc + (w_is32 ? 32'd4 : 32'd2);
            if (r_cyc && i_ack) begin
                if (r_drop) begin
                    r_drop <= 1'b0;
                    r_cyc  <= 1'b1;
                    r_addr <= {r_pc[31:2], 2'b00};
                end else begin
                    r_addr <= r_addr + 32'd4;
                    r_cyc  <= (w_level_nxt < FULL);
                end
            end else if (!r_cyc && !r_drop && (r_level < FULL)) begin
                r_cyc <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end
endmodule

// File: tb/tb_rv_fetch_queue.sv
// Bench for rv_fetch_queue: bus responder over a word memory, and a half-word stream decoder as the reference for every consumed instruction.
module tb_rv_fetch_queue;
    localparam logic [31:0] RST   = 32'h0000_0100;
    localparam int          DEPTH = 4;
    localparam int          LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        comp;
    } cons_t;

    logic             i_clk;
    logic             i_reset;
    logic [31:0]      i_pc_target;
    logic             i_pc_select;
    logic             i_ready;
    logic [31:0]      i_data;
    logic             i_ack;
    logic [31:0]      o_addr;
    logic             o_cyc;
    logic             o_valid;
    logic [31:0]      o_pc;
    logic [31:0]      o_instruction;
    logic             o_compressed;
    logic [LVL_W-1:0] o_level;

    logic [31:0] bmem [0:255];
    cons_t       cons_q [$];
    logic [31:0] ack_q [$];
    logic [31:0] m_pc;
    logic [31:0] prev_addr;
    bit          prev_pend, prev_sel;
    bit          hold_ack, rand_ack, force_ack;
    int          rdy_mode;
    int          n_checks, n_err, n_cons;

    rv_fetch_queue #(.RESET_ADDR(RST), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_pc_target(i_pc_target), .i_pc_select(i_pc_select),
        .i_ready(i_ready), .i_data(i_data), .i_ack(i_ack), .o_addr(o_addr), .o_cyc(o_cyc),
        .o_valid(o_valid), .o_pc(o_pc), .o_instruction(o_instruction), .o_compressed(o_compressed),
        .o_level(o_level)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = bmem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Architectural view: the program is a half-word stream; low bits 11 mean a 32-bit instruction.
    function automatic logic [31:0] exp_ins(input logic [31:0] pc);
        logic [15:0] h;
        h = hw_at(pc);
        if (h[1:0] == 2'b11) return {hw_at(pc + 32'd2), h};
        return {16'h0, h};
    endfunction

    function automatic logic [31:0] ack_at(input int i);
        if (i < ack_q.size()) return ack_q[i];
        return 'x;
    endfunction

    function automatic cons_t cons_at(input int i);
        if (i < cons_q.size()) return cons_q[i];
        return 'x;
    endfunction

    task automatic tick();
        logic [31:0] e;
        cons_t       c;
        if (force_ack) begin
            i_ack  = 1'b1;
            i_data = 32'hdead_beef;
        end else begin
            i_ack  = o_cyc && !hold_ack && (!rand_ack || ($urandom_range(0, 2) != 0));
            i_data = i_ack ? bmem[o_addr[9:2]] : $urandom;
        end
        case (rdy_mode)
            0:       i_ready = 1'b0;
            1:       i_ready = 1'b1;
            default: i_ready = ($urandom_range(0, 3) != 0);
        endcase
        @(negedge i_clk);
        if (prev_pend) begin
            chk("req_hold_cyc", {31'd0, o_cyc}, 32'd1);
            chk("req_hold_addr", o_addr, prev_addr);
        end
        if (prev_sel) begin
            chk("flush_valid", {31'd0, o_valid}, 32'd0);
            chk("flush_level", 32'(o_level), 32'd0);
        end
        chk("level_bound", {31'd0, (int'(o_level) <= DEPTH)}, 32'd1);
        if (i_reset) begin
            m_pc = {RST[31:1], 1'b0};
        end else if (i_pc_select) begin
            m_pc = {i_pc_target[31:1], 1'b0};
        end else if (o_valid && i_ready) begin
            e = exp_ins(m_pc);
            chk("cons_pc", o_pc, m_pc);
            chk("cons_ins", o_instruction, e);
            chk("cons_comp", {31'd0, o_compressed}, {31'd0, e[1:0] != 2'b11});
            c.pc = o_pc; c.ins = o_instruction; c.comp = o_compressed;
            cons_q.push_back(c);
            n_cons++;
            m_pc = m_pc + ((e[1:0] == 2'b11) ? 32'd4 : 32'd2);
        end
        if (!i_reset && o_cyc && i_ack) ack_q.push_back(o_addr);
        prev_pend = o_cyc && !i_ack && !i_reset;
        prev_addr = o_addr;
        prev_sel  = i_pc_select && !i_reset;
        @(posedge i_clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        i_pc_select = 1'b1;
        i_pc_target = tgt;
        tick();
        i_pc_select = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cyc"}, {31'd0, o_cyc}, 32'd0);
        chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "_comp"}, {31'd0, o_compressed}, 32'd0);
        chk({tag, "_level"}, 32'(o_level), 32'd0);
        chk({tag, "_ins"}, o_instruction, 32'd0);
        chk({tag, "_pc"}, o_pc, 32'h0000_0100);
        chk({tag, "_addr"}, o_addr, 32'h0000_0100);
    endtask

    initial begin
        cons_t c;
        logic [31:0] old_addr;
        int base_cons;
        n_checks = 0; n_err = 0; n_cons = 0;
        hold_ack = 0; rand_ack = 0; force_ack = 0; rdy_mode = 1;
        prev_pend = 0; prev_sel = 0; m_pc = RST;
        i_reset = 1'b1; i_pc_select = 1'b0; i_pc_target = 32'h0;
        i_ready = 1'b0; i_ack = 1'b0; i_data = 32'h0;
        for (int k = 0; k < 256; k++) bmem[k] = 32'h0000_0013;
        bmem[0]    = 32'h0003_4501;
        bmem[1]    = 32'h0000_0513;
        bmem[2]    = 32'h0001_0001;
        bmem[8'h80] = 32'h4503_1111;
        bmem[8'h81] = 32'h0000_0241;

        // Reset state, then straight-line 32-bit fetch from RESET_ADDR.
        tick(); tick();
        chk_reset_state("rst");
        i_reset = 1'b0;
        ack_q.delete(); cons_q.delete();
        for (int k = 0; k < 3; k++) tick();
        chk("valid_by_c3", {31'd0, cons_q.size() >= 1}, 32'd1);
        for (int k = 0; k < 4; k++) tick();
        chk("rst_ack0", ack_at(0), 32'h100);
        chk("rst_ack1", ack_at(1), 32'h104);
        c = cons_at(0); chk("rst_pc0", c.pc, 32'h100); chk("rst_comp0", {31'd0, c.comp}, 32'd0);
        c = cons_at(1); chk("rst_pc1", c.pc, 32'h104);

        // Mixed compressed / straddling stream.
        redirect(32'h0);
        cons_q.delete();
        for (int k = 0; k < 8; k++) tick();
        c = cons_at(0);
        chk("mix0_pc", c.pc, 32'h0); chk("mix0_ins", c.ins, 32'h0000_4501); chk("mix0_comp", {31'd0, c.comp}, 32'd1);
        c = cons_at(1);
        chk("mix1_pc", c.pc, 32'h2); chk("mix1_ins", c.ins, 32'h0513_0003); chk("mix1_comp", {31'd0, c.comp}, 32'd0);
        c = cons_at(2);
        chk("mix2_pc", c.pc, 32'h6); chk("mix2_comp", {31'd0, c.comp}, 32'd1);

        // Backpressure fills the queue and stops requests.
        rdy_mode = 0;
        redirect(32'h0);
        ack_q.delete();
        for (int k = 0; k < 12; k++) tick();
        chk("bp_level", 32'(o_level), 32'd4);
        chk("bp_cyc", {31'd0, o_cyc}, 32'd0);
        chk("bp_valid", {31'd0, o_valid}, 32'd1);
        chk("bp_acks", ack_q.size(), 32'd4);
        ack_q.delete();
        rdy_mode = 1;
        for (int k = 0; k < 6; k++) tick();
        chk("bp_resume_addr", ack_at(0), 32'h10);

        // Redirect into an upper half-word while a request is stalled.
        hold_ack = 1;
        for (int k = 0; k < 8 && !o_cyc; k++) tick();
        chk("drop_pend", {31'd0, o_cyc}, 32'd1);
        old_addr = o_addr;
        redirect(32'h202);
        chk("drop_cyc", {31'd0, o_cyc}, 32'd1);
        chk("drop_addr", o_addr, old_addr);
        chk("drop_pc", o_pc, 32'h202);
        tick(); tick();
        hold_ack = 0;
        ack_q.delete(); cons_q.delete();
        for (int k = 0; k < 6; k++) tick();
        chk("drop_ack_old", ack_at(0), old_addr);
        chk("drop_ack_tgt", ack_at(1), 32'h200);
        c = cons_at(0);
        chk("drop_first_pc", c.pc, 32'h202);
        chk("drop_first_ins", c.ins, 32'h0241_4503);

        // Redirect, ack and consume all in one cycle.
        for (int k = 0; k < 10 && !(o_valid && o_cyc); k++) tick();
        chk("sim_pre", {30'd0, o_valid, o_cyc}, 32'd3);
        redirect(32'h40);
        chk("sim_pc", o_pc, 32'h40);
        chk("sim_addr", o_addr, 32'h40);
        for (int k = 0; k < 8; k++) tick();

        // Reset during an outstanding request, then a late acknowledge.
        hold_ack = 1;
        for (int k = 0; k < 8 && !o_cyc; k++) tick();
        chk("rst2_pend", {31'd0, o_cyc}, 32'd1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk_reset_state("rst2");
        force_ack = 1;
        tick();
        force_ack = 0;
        chk("late_level", 32'(o_level), 32'd0);
        chk("late_cyc", {31'd0, o_cyc}, 32'd1);
        chk("late_addr", o_addr, 32'h100);
        hold_ack = 0;
        ack_q.delete(); cons_q.delete();
        for (int k = 0; k < 6; k++) tick();
        chk("rst2_ack0", ack_at(0), 32'h100);
        c = cons_at(0);
        chk("rst2_pc0", c.pc, 32'h100);
        chk("rst2_ins0", c.ins, 32'h0000_0013);

        // Random program, random bus waits, random stalls and redirects.
        for (int k = 0; k < 256; k++) bmem[k] = $urandom;
        redirect(32'h0);
        rand_ack = 1; rdy_mode = 2;
        base_cons = n_cons;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 63) == 0) redirect(32'($urandom_range(0, 1023)));
            else tick();
        end
        chk("rand_progress", {31'd0, (n_cons - base_cons) >= 300}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
